// File: rtl/sample_capture_fifo.sv
// ---------------------------------------------------------------------------
// sample_capture_fifo
//
// Captures one sample per clock-generator strobe into a small
// first-word-fall-through FIFO. It also watches the strobe cadence and
// raises sticky flags when a sample is dropped or the cadence is wrong.
//
// Parameters
//   DATA_W  sample width in bits
//   DEPTH   FIFO entries (power of 2, >= 2)
//   PERIOD  expected CLK_24M cycles between consecutive strobes
//
// Ports
//   CLK_24M            system clock, rising edge
//   reset              asynchronous, active-low reset
//   enable_sampling_3M one-cycle sample strobe
//   sample_in          sample captured on strobe cycles
//   out_data           FIFO head (0 while in reset)
//   out_valid          FIFO non-empty
//   out_ready          consumer pops the head this cycle
//   level              occupancy, 0..DEPTH
//   overflow           sticky: a strobe arrived while full with no pop
//   strobe_err         sticky: strobe gap differed from PERIOD, or a strobe was missed
//   clear              synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module sample_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 8
) (
    input  logic                    CLK_24M,
    input  logic                    reset,
    input  logic                    enable_sampling_3M,
    input  logic [DATA_W-1:0]       sample_in,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    strobe_err,
    input  logic                    clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // The gap counter must be able to hold PERIOD+1, where it saturates.
    localparam int GW = $clog2(PERIOD + 2);

    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_PERIOD = GW'(PERIOD);
    localparam logic [GW-1:0] GAP_MAX    = GW'(PERIOD + 1);

    localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
    localparam logic [0:0] ST_TRACK      = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          strobe_err_q, strobe_err_d;
    logic [0:0]    mon_state_q, mon_state_d;
    logic [GW-1:0] gap_q, gap_d;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic cadence_err;

    assign out_valid  = (level_q != '0);
    assign full       = (level_q == LVL_FULL);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign strobe_err = strobe_err_q;

    // Storage is not reset; out_data is forced to zero while reset is held.
    assign out_data = reset ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop  = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = enable_sampling_3M && (!full || pop);
        drop = enable_sampling_3M && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // gap_q holds the cycle distance from the last strobe to the
        // current cycle; it restarts at 1 on the cycle after each strobe.
        mon_state_d = mon_state_q;
        gap_d       = gap_q;
        cadence_err = 1'b0;
        if (enable_sampling_3M) begin
            mon_state_d = ST_TRACK;
            gap_d       = GW'(1);
            if (mon_state_q == ST_TRACK && gap_q != GAP_PERIOD) begin
                cadence_err = 1'b1;
            end
        end else if (mon_state_q == ST_TRACK && gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
            // Expected strobe cycle passed without a strobe. Firing only on
            // the step to PERIOD+1 lets clear take effect while strobes stay absent.
            if (gap_q == GAP_PERIOD) begin
                cadence_err = 1'b1;
            end
        end

        // A setting event wins over a coincident clear.
        overflow_d   = (overflow_q   && !clear) || drop;
        strobe_err_d = (strobe_err_q && !clear) || cadence_err;
    end

    always_ff @(posedge CLK_24M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            strobe_err_q <= 1'b0;
            mon_state_q  <= ST_WAIT_FIRST;
            gap_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            strobe_err_q <= strobe_err_d;
            mon_state_q  <= mon_state_d;
            gap_q        <= gap_d;
        end
    end

endmodule

// File: doc/sample_capture_fifo.md
SAMPLE_CAPTURE_FIFO -- requirements
Module: sample_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter PERIOD, default 8: expected number of CLK_24M cycles between strobes.
REQ-004 SHALL have port CLK_24M, input, 1 bit: system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable_sampling_3M, input, 1 bit: one-cycle sample strobe from the clock generator.
REQ-007 SHALL have port sample_in, input, DATA_W bits: sample to capture; valid on strobe cycles.
REQ-008 SHALL have port out_data, output, DATA_W bits: FIFO head sample.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the head this cycle.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag; a sample was dropped.
REQ-013 SHALL have port strobe_err, output, 1 bit: sticky flag; strobe cadence violated.
REQ-014 SHALL have port clear, input, 1 bit: synchronous clear of the sticky flags.

Function
REQ-015 SHALL push sample_in into the FIFO on every cycle with enable_sampling_3M=1, unless the push is dropped under REQ-018.
REQ-016 SHALL be first-word-fall-through: out_valid=(level!=0); out_data=oldest entry; out_data don't-care when out_valid=0.
REQ-017 SHALL pop one entry on each cycle with out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-018 SHALL, on a strobe with level=DEPTH and no pop that cycle, drop the new sample, leave FIFO contents unchanged, and set overflow on the next edge.
REQ-019 SHALL, on push with pop in the same cycle, accept both, leave level unchanged, and not set overflow, including when level=DEPTH.
REQ-020 SHALL, on push into an empty FIFO, present the sample with out_valid=1 on the cycle after the strobe (latency 1).
REQ-021 SHALL use wrap-around read/write pointers of clog2(DEPTH) bits; level SHALL be a separate counter and SHALL never exceed DEPTH or underflow.
REQ-022 SHALL implement a cadence monitor with two states:
- WAIT_FIRST: entered at reset; ignores gap length; moves to TRACK on the first strobe.
- TRACK: counts cycles since the last strobe; remains in TRACK for the rest of operation.
REQ-023 SHALL, in TRACK, on a strobe with gap != PERIOD, set strobe_err; gap = cycle distance between consecutive strobe cycles.
REQ-024 SHALL, in TRACK, set strobe_err when gap reaches PERIOD+1 with no strobe (missing strobe); the gap counter SHALL saturate and SHALL NOT wrap.
REQ-025 SHALL, on each strobe, restart the gap count, including strobes that raise strobe_err.
REQ-026 SHALL keep overflow and strobe_err set until clear=1 or reset; when clear and a new setting event coincide, the flag SHALL remain set.
REQ-027 SHALL leave the FIFO and the monitor state unaffected by clear.

Reset
REQ-028 SHALL, while reset=0, hold level=0, out_valid=0, overflow=0, strobe_err=0, pointers at 0, and the monitor in WAIT_FIRST.
REQ-029 SHALL drive out_data=0 while reset=0.
REQ-030 SHALL apply reset asynchronously at any time, including mid-push or mid-pop; FIFO contents are discarded.
REQ-031 SHALL ignore any strobe coinciding with reset release, and SHALL capture from the first strobe seen with reset=1 at the clock edge.

Verification
REQ-032 Nominal: strobe every 8 cycles, sample_in=0x10,0x11,0x12, out_ready=1 -> out_data sequence 0x10,0x11,0x12, each out_valid one cycle after its strobe; level never exceeds 1; strobe_err=0.
REQ-033 Overflow: out_ready=0, 5 strobes with 0xA0..0xA4 -> level=4, overflow=1 after the 5th strobe; then out_ready=1 drains 0xA0..0xA3 only.
REQ-034 Full + simultaneous: level=4, strobe and pop in the same cycle -> level stays 4, overflow=0, the new sample is the last entry out.
REQ-035 Cadence: strobe gaps 8,8,6 -> strobe_err set on the gap-6 strobe; after clear, a strobe stopped for 9 cycles -> strobe_err set on the 9th cycle.
REQ-036 Clear vs event: clear=1 on the same cycle as a dropped push -> overflow remains 1; clear alone next cycle -> overflow=0.
REQ-037 Reset mid-operation: level=3, assert reset -> level=0, out_valid=0, flags 0 immediately; after release, the first strobe does not raise strobe_err.
